// File: rtl/rot_enc_mux_ctrl_pkg.sv
// Shared types and gray-code step classification for the multiplexed encoder controller.
package rot_enc_pkg;

    localparam int FC_W = 4;

    typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR} step_t;
    typedef enum logic [1:0] {INIT, PRIME, SCAN} fsm_t;

    // Position of {B,A} in the forward sequence 00 -> 01 -> 11 -> 10.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic step_t gray_step(input logic [1:0] old_ab, input logic [1:0] new_ab);
        logic [1:0] d;
        d = gray_pos(new_ab) - gray_pos(old_ab);
        case (d)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_FWD;
            2'd3:    return STEP_REV;
            default: return STEP_ERR;
        endcase
    endfunction

endpackage

// File: rtl/rot_enc_mux_ctrl_if.sv
// Host read/clear port of the encoder controller.
interface rot_enc_mux_ctrl_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 32
);
    localparam int CH_W = $clog2(N_CH);

    logic             ready;
    logic             rd_req;
    logic [CH_W-1:0]  rd_ch;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_count;
    logic             rd_error;
    logic             clr_req;
    logic [CH_W-1:0]  clr_ch;

    modport master (
        input  ready, rd_valid, rd_count, rd_error,
        output rd_req, rd_ch, clr_req, clr_ch
    );

    modport slave (
        output ready, rd_valid, rd_count, rd_error,
        input  rd_req, rd_ch, clr_req, clr_ch
    );

endinterface

// File: rtl/rot_enc_mux_ctrl_step.sv
// Combinational glitch filter and gray-step decoder for the channel being visited.
module rot_enc_step
    import rot_enc_pkg::*;
#(
    parameter int FLT_LEN = 4,
    parameter int CNT_W   = 32
) (
    input  logic [1:0]       i_sample,
    input  logic [1:0]       i_stable,
    input  logic [1:0]       i_cand,
    input  logic [FC_W-1:0]  i_fcnt,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_err,
    output logic [1:0]       o_stable,
    output logic [1:0]       o_cand,
    output logic [FC_W-1:0]  o_fcnt,
    output logic [CNT_W-1:0] o_count,
    output logic             o_err
);

    logic [FC_W-1:0] w_fnext;

    always_comb begin
        o_stable = i_stable;
        o_cand   = i_cand;
        o_fcnt   = i_fcnt;
        o_count  = i_count;
        o_err    = i_err;
        w_fnext  = '0;
        if (i_sample == i_stable) begin
            o_fcnt = '0;
        end else begin
            w_fnext = (i_sample == i_cand) ? i_fcnt + FC_W'(1) : '0;
            o_cand  = i_sample;
            // A fresh candidate starts at 0, so FLT_LEN=1 accepts immediately.
            if (w_fnext == FC_W'(FLT_LEN - 1)) begin
                o_stable = i_sample;
                o_fcnt   = '0;
                case (gray_step(i_stable, i_sample))
                    STEP_FWD: o_count = i_count + CNT_W'(1);
                    STEP_REV: o_count = i_count - CNT_W'(1);
                    STEP_ERR: o_err   = 1'b1;
                    default:  ;
                endcase
            end else begin
                o_fcnt = w_fnext;
            end
        end
    end

endmodule

// File: rtl/rot_enc_mux_ctrl.sv
// Round-robin quadrature decoder: one shared filter/decode step visits one channel per clock.
// INIT  | zero state of visited channel ; PRIME | load stable from inputs ; SCAN | filter/decode
module rot_enc_mux_ctrl
    import rot_enc_pkg::*;
#(
    parameter int N_CH    = 8,
    parameter int FLT_LEN = 4,
    parameter int CNT_W   = 32
) (
    input  logic            clock,
    input  logic            aclr_n,
    input  logic [N_CH-1:0] enc_a,
    input  logic [N_CH-1:0] enc_b,
    rot_enc_mux_ctrl_if.slave host
);

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]  r_a_m, r_a_s, r_b_m, r_b_s;
    logic [CH_W-1:0]  r_ch_idx;
    fsm_t             r_state, w_state_nxt;
    logic             r_ready;

    logic [1:0]       r_stable [N_CH];
    logic [1:0]       r_cand   [N_CH];
    logic [FC_W-1:0]  r_fcnt   [N_CH];
    logic [CNT_W-1:0] r_count  [N_CH];
    logic             r_err    [N_CH];

    logic             r_rd_pend;
    logic [CH_W-1:0]  r_rd_ch;
    logic             r_rd_valid;
    logic [CNT_W-1:0] r_rd_count;
    logic             r_rd_error;

    logic             w_last;
    logic [1:0]       w_sample;
    logic [1:0]       w_stable_nxt, w_cand_nxt;
    logic [FC_W-1:0]  w_fcnt_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_err_nxt;
    logic             w_clr_ok;
    logic             w_rd_ok;

    assign w_last   = (r_ch_idx == CH_W'(N_CH - 1));
    assign w_sample = {r_b_s[r_ch_idx], r_a_s[r_ch_idx]};
    assign w_clr_ok = host.clr_req && (r_state == SCAN) && (int'(host.clr_ch) < N_CH);
    assign w_rd_ok  = r_rd_pend && r_ready && (int'(r_rd_ch) < N_CH);

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_a_m    <= '0;
            r_a_s    <= '0;
            r_b_m    <= '0;
            r_b_s    <= '0;
            r_ch_idx <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_a_m    <= enc_a;
            r_a_s    <= r_a_m;
            r_b_m    <= enc_b;
            r_b_s    <= r_b_m;
            r_ch_idx <= w_last ? '0 : r_ch_idx + CH_W'(1);
            r_ready  <= (w_state_nxt == SCAN);
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) r_state <= INIT;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (w_last) w_state_nxt = PRIME;
            PRIME:   if (w_last) w_state_nxt = SCAN;
            SCAN:    w_state_nxt = SCAN;
            default: w_state_nxt = INIT;
        endcase
    end

    rot_enc_step #(
        .FLT_LEN (FLT_LEN),
        .CNT_W   (CNT_W)
    ) u_step (
        .i_sample (w_sample),
        .i_stable (r_stable[r_ch_idx]),
        .i_cand   (r_cand[r_ch_idx]),
        .i_fcnt   (r_fcnt[r_ch_idx]),
        .i_count  (r_count[r_ch_idx]),
        .i_err    (r_err[r_ch_idx]),
        .o_stable (w_stable_nxt),
        .o_cand   (w_cand_nxt),
        .o_fcnt   (w_fcnt_nxt),
        .o_count  (w_count_nxt),
        .o_err    (w_err_nxt)
    );

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_stable[i] <= '0;
                r_cand[i]   <= '0;
                r_fcnt[i]   <= '0;
                r_count[i]  <= '0;
                r_err[i]    <= 1'b0;
            end
        end else begin
            case (r_state)
                INIT: begin
                    r_stable[r_ch_idx] <= '0;
                    r_cand[r_ch_idx]   <= '0;
                    r_fcnt[r_ch_idx]   <= '0;
                    r_count[r_ch_idx]  <= '0;
                    r_err[r_ch_idx]    <= 1'b0;
                end
                PRIME: begin
                    r_stable[r_ch_idx] <= w_sample;
                    r_cand[r_ch_idx]   <= w_sample;
                    r_fcnt[r_ch_idx]   <= '0;
                end
                SCAN: begin
                    r_stable[r_ch_idx] <= w_stable_nxt;
                    r_cand[r_ch_idx]   <= w_cand_nxt;
                    r_fcnt[r_ch_idx]   <= w_fcnt_nxt;
                    r_count[r_ch_idx]  <= w_count_nxt;
                    r_err[r_ch_idx]    <= w_err_nxt;
                end
                default: ;
            endcase
            // Placed last so a clear overrides a same-cycle step on that channel.
            if (w_clr_ok) begin
                r_count[host.clr_ch] <= '0;
                r_err[host.clr_ch]   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_ch    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_count <= '0;
            r_rd_error <= 1'b0;
        end else begin
            r_rd_pend  <= host.rd_req;
            r_rd_ch    <= host.rd_ch;
            r_rd_valid <= r_rd_pend;
            if (w_rd_ok) begin
                r_rd_count <= r_count[r_rd_ch];
                r_rd_error <= r_err[r_rd_ch];
            end else begin
                r_rd_count <= '0;
                r_rd_error <= 1'b0;
            end
        end
    end

    assign host.ready    = r_ready;
    assign host.rd_valid = r_rd_valid;
    assign host.rd_count = r_rd_count;
    assign host.rd_error = r_rd_error;

endmodule

// File: doc/rot_enc_mux_ctrl.md
Name: rot_enc_mux_ctrl

Overview:
Time-multiplexed controller for up to N quadrature rotary encoders that share one filter/decode datapath. A round-robin scheduler visits one channel per clock and applies glitch filtering, gray-step decoding and signed counting. Per-channel state is held in register arrays. A host-side read/clear port sits beside the scheduler and replaces the per-encoder counter instances in the motor-control fabric.

Parameters:
N_CH, 8, number of encoder channels (2..16)
FLT_LEN, 4, consecutive identical visits required before a new A/B state is accepted (1..15)
CNT_W, 32, signed position counter width

Ports:
clock  in  1  system clock
aclr_n  in  1  asynchronous active-low reset
enc_a  in  N_CH  raw encoder A inputs, asynchronous
enc_b  in  N_CH  raw encoder B inputs, asynchronous
ready  out  1  high once scheduler is in SCAN
rd_req  in  1  single-cycle read strobe
rd_ch  in  $clog2(N_CH)  channel to read
rd_valid  out  1  read data valid pulse
rd_count  out  CNT_W  signed counter of rd_ch
rd_error  out  1  sticky illegal-transition flag of rd_ch
clr_req  in  1  single-cycle clear strobe
clr_ch  in  $clog2(N_CH)  channel to clear

Behaviour:
- Reset (aclr_n low, async): state=INIT, ch_idx=0, all outputs 0, all synchronizers 0.
- Inputs pass through 2-FF synchronizers per channel, then are sampled only on that channel's visit.
- FSM:
  - INIT: zero the count, error, filter counter and stable state of ch_idx; after N_CH cycles go to PRIME.
  - PRIME: one full sweep; each visit loads stable state = synced {B,A} with no count. Then go to SCAN.
  - SCAN: normal operation, forever.
- ch_idx increments every clock and wraps N_CH-1 -> 0 in all states.
- ready=1 on the first SCAN cycle. Registered outputs.
- Filter, per visit in SCAN:
  - If sample == stable: filter counter = 0.
  - Else if sample == candidate: filter counter increments. When it reaches FLT_LEN-1, accept: stable = sample, filter counter = 0.
  - Else: candidate = sample, filter counter = 0.
  - Result: acceptance happens on the FLT_LEN-th consecutive identical visit (FLT_LEN=1 accepts on first differing visit).
- Decode on accept, using gray order 00->01->11->10->00 on {B,A}:
  - Forward step: count+1.
  - Reverse step: count-1.
  - Both bits changed: error=1 (sticky), count unchanged, stable still updated.
- Count wraps modulo 2^CNT_W: 0x7FFFFFFF+1 -> 0x80000000.
- Read:
  - rd_req sampled in any state.
  - rd_valid pulses exactly 2 cycles after rd_req.
  - Data is the channel state as of the cycle after rd_req, so it includes an update of that channel committed in the rd_req cycle.
  - Back-to-back rd_req every cycle is supported, fully pipelined.
  - Before ready, reads return 0/0.
- Clear:
  - clr_req zeroes count and error of clr_ch in the next cycle.
  - If the scheduler updates the same channel in the same cycle, clear wins and the step is lost.
  - Filter and stable state are untouched.
  - Ignored outside SCAN.
- Max supported edge rate per channel: f_clock/(N_CH*FLT_LEN). Faster inputs may set error.
- aclr_n asserted mid-operation: immediate return to INIT; all counts lost.

Decomposition:
- Package rot_enc_pkg:
  - typedef enum logic[1:0] step_t {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR}
  - typedef enum fsm_t {INIT, PRIME, SCAN}
  - function gray_step(old, new) returning step_t
- Sub-module rot_enc_step: combinational filter + decode for one channel.
  - Inputs: sample, stable, candidate, filter counter, count, error.
  - Outputs: next values of the same fields.
  - Instantiated once and shared by the scheduler.

Test Plan:
- Reset release with N_CH=4, FLT_LEN=3: ready rises exactly 2*N_CH=8 cycles after aclr_n high; rd of every channel returns count 0, error 0.
- Channel 2 driven forward 100 gray steps at 1 step per 200 cycles, other channels static -> rd_ch=2 returns 100; channels 0,1,3 return 0; error 0.
- Channel 1 driven 40 forward then 65 reverse steps -> count -25 (0xFFFFFFE7); simultaneous random stepping on all channels matches a per-channel reference model.
- Glitch of 2 visits (< FLT_LEN) on A of channel 0 -> no count change. A 00->11 jump held 3 visits -> error=1, count unchanged; clr_req ch0 -> count 0, error 0.
- Channel 3 preset near max by 0x7FFFFFFF steps (CNT_W=8 build: 127 steps) then +1 -> wraps to -128; rd_req every cycle for 20 cycles -> 20 rd_valid pulses, each 2 cycles after its request.
- aclr_n pulsed low mid-stepping -> outputs 0 immediately; after re-init, counts 0 and stepping resumes correctly from the current input state.
